// File: rtl/ravan_key_scheduler.sv
// ravan_key_scheduler
//   Round-key scheduler for the RAVAN-A 512-bit engine. Captures a master key,
//   then issues one 64-bit round key per round over a valid/ready handshake.
//   After every 8th issued round the held key is rotated left by ROT, so that
//   later 8-round groups draw different slices. The held key is cleared on
//   completion and on abort, so no key material stays resident while idle.
//
//   Ports
//     clk, rst               clock, asynchronous active-high reset
//     key, key_valid         master key and load request
//     key_ready              high only while idle
//     abort                  synchronous cancel, highest priority
//     rk_data, rk_index      current round key and round number
//     rk_valid, rk_ready     round-key handshake
//     busy                   high while issuing
//     done                   one-cycle pulse after the last key is accepted
//
//   DynamicKeySlicer (built into this module)
//     Slice i is the 64-bit circular window of the held key that starts at
//     bit OFFSET[i]; bit k of the slice is key_q[(OFFSET[i] + k) mod 512].
//     Slices 1 and 6 share a window; the round index XORed into rk_data
//     keeps their round keys distinct.
module ravan_key_scheduler #(
  parameter int unsigned NUM_ROUNDS = 16,
  parameter int unsigned ROT        = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] key,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic         abort,
  output logic [63:0]  rk_data,
  output logic [7:0]   rk_index,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } state_t;

  localparam int unsigned OFFSET [8] = '{10, 453, 74, 138, 202, 266, 453, 330};
  localparam logic [7:0]  LAST_ROUND = 8'(NUM_ROUNDS - 1);

  state_t       state_q, state_d;
  logic [511:0] key_q, key_d;
  logic [7:0]   round_q, round_d;
  logic         done_q, done_d;

  // DynamicKeySlicer: doubling the key turns each circular window into a
  // plain part-select (largest index used is 453 + 63 < 1024).
  logic [1023:0]     key_dbl;
  logic [7:0][63:0]  sliced_key;

  assign key_dbl = {key_q, key_q};

  always_comb begin
    sliced_key = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      sliced_key[i] = key_dbl[OFFSET[i] +: 64];
    end
  end

  // rotl(key_q, ROT); legal ROT range 1..511 keeps both shifts in range.
  logic [511:0] key_rot;
  assign key_rot = (key_q << ROT) | (key_q >> (512 - ROT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;

    if (abort) begin
      // Cancel wins over load and transfer; no done pulse is raised.
      state_d = S_IDLE;
      key_d   = '0;
      round_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (key_valid) begin
            key_d   = key;
            round_d = '0;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (rk_ready) begin
            if (round_q == LAST_ROUND) begin
              done_d  = 1'b1;
              key_d   = '0;
              round_d = '0;
              state_d = S_IDLE;
            end else begin
              round_d = round_q + 8'd1;
              // Rotate only at the boundary between 8-round groups.
              if (round_q[2:0] == 3'd7) begin
                key_d = key_rot;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign key_ready = (state_q == S_IDLE);
  assign rk_valid  = (state_q == S_ISSUE);
  assign busy      = (state_q == S_ISSUE);
  assign done      = done_q;
  assign rk_index  = round_q;
  assign rk_data   = sliced_key[round_q[2:0]] ^ {56'b0, round_q};

endmodule

// File: tb/tb_ravan_key_scheduler.sv
module tb_ravan_key_scheduler;

  localparam int NR  = 16;
  localparam int ROT = 13;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] key;
  logic         key_valid;
  logic         key_ready;
  logic         abort;
  logic [63:0]  rk_data;
  logic [7:0]   rk_index;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  ravan_key_scheduler #(.NUM_ROUNDS(NR), .ROT(ROT)) dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .abort     (abort),
    .rk_data   (rk_data),
    .rk_index  (rk_index),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int OFFS [8] = '{10, 453, 74, 138, 202, 266, 453, 330};

  function automatic logic [511:0] m_rotl(input logic [511:0] x, input int n);
    logic [511:0] r;
    for (int b = 0; b < 512; b++) r[(b + n) % 512] = x[b];
    return r;
  endfunction

  function automatic logic [63:0] m_slice(input logic [511:0] k, input int i);
    logic [63:0] s;
    for (int b = 0; b < 64; b++) s[b] = k[(OFFS[i] + b) % 512];
    return s;
  endfunction

  bit           m_active;
  logic [511:0] m_master;
  int           m_round;
  bit           m_done;

  // Transaction-level view: the key seen in round r is the master key
  // rotated by ROT once per completed 8-round group.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_master = '0;
      m_round  = 0;
      m_done   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (abort) begin
        m_active = 1'b0;
        m_round  = 0;
      end else if (!m_active) begin
        if (key_valid) begin
          m_active = 1'b1;
          m_master = key;
          m_round  = 0;
        end
      end else if (rk_ready) begin
        if (m_round == NR - 1) begin
          m_done   = 1'b1;
          m_active = 1'b0;
          m_round  = 0;
        end else begin
          m_round++;
        end
      end
    end
  end

  function automatic logic [63:0] m_rk(input bit act, input logic [511:0] mk, input int r);
    if (!act) return 64'h0;
    return m_slice(m_rotl(mk, (ROT * (r / 8)) % 512), r % 8) ^ 64'(r);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_rk_valid",  64'(rk_valid),  64'(m_active));
      chk("cyc_busy",      64'(busy),      64'(m_active));
      chk("cyc_key_ready", 64'(key_ready), 64'(!m_active));
      chk("cyc_done",      64'(done),      64'(m_done));
      chk("cyc_rk_index",  64'(rk_index),  64'(m_active ? m_round : 0));
      chk("cyc_rk_data",   rk_data,        m_rk(m_active, m_master, m_round));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_done(input string name, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (done) break;
      step();
    end
    chk({name, "_done_seen"}, 64'(done), 64'h1);
  endtask

  task automatic load(input logic [511:0] k);
    key       = k;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
  endtask

  logic [511:0] key_b;
  logic [511:0] key_c;

  initial begin
    rst       = 1'b1;
    key       = '0;
    key_valid = 1'b0;
    abort     = 1'b0;
    rk_ready  = 1'b0;
    key_b     = 512'h1 << 5;
    key_c     = {8{64'hA5C3_0F1E_9B7D_2468}};
    step();
    step();
    // Reset values
    chk("rst_key_ready", 64'(key_ready), 64'h1);
    chk("rst_rk_valid",  64'(rk_valid),  64'h0);
    chk("rst_busy",      64'(busy),      64'h0);
    chk("rst_done",      64'(done),      64'h0);
    chk("rst_rk_index",  64'(rk_index),  64'h0);
    chk("rst_rk_data",   rk_data,        64'h0);
    rst = 1'b0;
    step();
    chk_en = 1'b1;

    // Basic issue sequence, key = 1
    rk_ready = 1'b1;
    load(512'h1);
    for (int r = 0; r < NR; r++) begin
      chk("basic_index", 64'(rk_index), 64'(r));
      if (r == 0) chk("basic_rk0", rk_data, 64'h0);
      if (r == 1) chk("basic_rk1", rk_data, 64'h0800_0000_0000_0001);
      if (r == 6) chk("basic_rk6", rk_data, 64'h0800_0000_0000_0006);
      if (r == 8) chk("basic_rk8", rk_data, 64'h0);
      step();
    end
    chk("basic_done",      64'(done),      64'h1);
    chk("basic_key_ready", 64'(key_ready), 64'h1);
    step();
    chk("basic_done_1cyc", 64'(done), 64'h0);

    // Backpressure at round 3
    load(512'h1);
    repeat (3) step();
    rk_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_index", 64'(rk_index), 64'h3);
      chk("bp_data",  rk_data,       64'h3);
      chk("bp_valid", 64'(rk_valid), 64'h1);
      step();
    end
    rk_ready = 1'b1;
    chk("bp_resume_index", 64'(rk_index), 64'h3);
    step();
    chk("bp_next_index", 64'(rk_index), 64'h4);
    run_until_done("bp", 40);
    step();

    // Abort at round 5 together with a transfer, then immediate reload
    load(512'h1);
    repeat (5) step();
    chk("ab_at5", 64'(rk_index), 64'h5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_valid", 64'(rk_valid), 64'h0);
    chk("ab_done",  64'(done),     64'h0);
    chk("ab_index", 64'(rk_index), 64'h0);
    load(512'h1);
    chk("ab_reload_index", 64'(rk_index), 64'h0);
    chk("ab_reload_rk0",   rk_data,       64'h0);
    step();
    chk("ab_reload_rk1",   rk_data,       64'h0800_0000_0000_0001);
    run_until_done("ab", 40);
    step();

    // Asynchronous reset mid-ISSUE at round 10
    load(512'h1);
    repeat (10) step();
    chk("mr_at10", 64'(rk_index), 64'd10);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_rk_valid",  64'(rk_valid),  64'h0);
    chk("mr_busy",      64'(busy),      64'h0);
    chk("mr_key_ready", 64'(key_ready), 64'h1);
    chk("mr_rk_index",  64'(rk_index),  64'h0);
    chk("mr_rk_data",   rk_data,        64'h0);
    chk("mr_done",      64'(done),      64'h0);
    step();
    rst = 1'b0;
    step();

    // Back-to-back: key B loaded in A's done cycle
    load(512'h1);
    repeat (NR) step();
    chk("b2b_done", 64'(done), 64'h1);
    load(key_b);
    chk("b2b_index0", 64'(rk_index), 64'h0);
    chk("b2b_rk0",    rk_data,       64'h0);
    repeat (8) step();
    chk("b2b_rk8",    rk_data,       64'h108);
    run_until_done("b2b", 40);
    step();

    // key_valid held through ISSUE with changing key: ignored
    key       = key_c;
    key_valid = 1'b1;
    step();
    key = ~key_c;
    for (int i = 0; i < NR; i++) begin
      chk("ig_key_ready", 64'(key_ready), 64'h0);
      step();
    end
    chk("ig_done", 64'(done), 64'h1);
    step();   // reload of the held request happens here
    key_valid = 1'b0;
    chk("ig_reload_valid", 64'(rk_valid), 64'h1);
    run_until_done("ig", 40);
    step();
    step();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
